// File: rtl/tx_arbiter.sv
// tx_arbiter: two-requester round-robin arbiter feeding a serial transmitter.
// A grant latches the winning byte, pulses tx_send plus the winner's ack for
// one cycle (LOAD), then holds off for the frame time (WAIT) and an optional
// idle gap (GAP) before the next grant can be considered in IDLE.
//
// Handshake: a requester holds reqN high with dataN stable until it sees a
// one-cycle ackN; a req still high after its ack is a fresh byte. req levels
// are only looked at in IDLE, so nothing is queued while a frame is running.
module tx_arbiter #(
   parameter int FRAME_CYCLES = 12,
   parameter int GAP_CYCLES   = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       tx_send,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic [7:0] byte_cnt,
   output logic [1:0] dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_WAIT = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   localparam int CW = 16;
   localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ptr_q, ptr_d;
   logic          tx_send_q, tx_send_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          busy_q, busy_d;
   logic [7:0]    byte_cnt_q, byte_cnt_d;
   logic          pick;

   // State, counters and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ptr_q      <= 1'b0;
         tx_send_q  <= 1'b0;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
         byte_cnt_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         tx_send_q  <= tx_send_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         tx_data_q  <= tx_data_d;
         busy_q     <= busy_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   // Next state and next registered outputs; strobes default low so they
   // last exactly the LOAD cycle.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      tx_send_d  = 1'b0;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      tx_data_d  = tx_data_q;
      byte_cnt_d = byte_cnt_q;
      // Contention goes to the pointer holder; otherwise the lone requester.
      pick       = (req0 && req1) ? ptr_q : req1;

      case (state_q)
         S_IDLE: begin
            if (en && (req0 || req1)) begin
               state_d   = S_LOAD;
               tx_send_d = 1'b1;
               ack0_d    = ~pick;
               ack1_d    = pick;
               tx_data_d = pick ? data1 : data0;
               // The pointer only rotates when both were competing.
               if (req0 && req1) begin
                  ptr_d = ~ptr_q;
               end
            end
         end
         S_LOAD: begin
            state_d    = S_WAIT;
            cnt_d      = '0;
            byte_cnt_d = byte_cnt_q + 8'd1;
         end
         S_WAIT: begin
            if (cnt_q == FRAME_LAST) begin
               cnt_d   = '0;
               state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   assign tx_send   = tx_send_q;
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign tx_data   = tx_data_q;
   assign busy      = busy_q;
   assign byte_cnt  = byte_cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed and random stimulus for tx_arbiter. The reference
// model works purely in cycle numbers: a grant at cycle g owns the link for
// FRAME+GAP+2 cycles, the send/ack pulse is seen at g+1 and the frame count
// bumps at g+2. Two instances run: defaults, and GAP_CYCLES=3.
module tb_tx_arbiter;

   localparam int F = 12;

   logic       clk = 1'b0;
   logic       rst_n, en, req0, req1;
   logic [7:0] data0, data1;

   logic       a_ack0, a_ack1, a_send, a_busy;
   logic [7:0] a_data, a_cnt;
   logic [1:0] a_st;
   logic       g_ack0, g_ack1, g_send, g_busy;
   logic [7:0] g_data, g_cnt;
   logic [1:0] g_st;

   bit         sel;
   logic       o_ack0, o_ack1, o_send, o_busy;
   logic [7:0] o_data, o_cnt;
   logic [1:0] o_st;

   int n_chk = 0;
   int n_fail = 0;

   // reference model
   int         cyc = 0;
   int         g_at = -1000;
   int         free_at = 0;
   bit         rr = 1'b0;
   bit         w_last = 1'b0;
   logic [7:0] exp_data = 8'h00;
   logic [7:0] exp_cnt = 8'h00;
   int         send_q[$];
   logic [7:0] data_q[$];

   always #5 clk = ~clk;

   tx_arbiter #(.FRAME_CYCLES(F), .GAP_CYCLES(0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req0(req0), .req1(req1),
      .data0(data0), .data1(data1), .ack0(a_ack0), .ack1(a_ack1),
      .tx_send(a_send), .tx_data(a_data), .busy(a_busy), .byte_cnt(a_cnt),
      .dbg_state(a_st)
   );

   tx_arbiter #(.FRAME_CYCLES(F), .GAP_CYCLES(3)) dut_gap (
      .clk(clk), .rst_n(rst_n), .en(en), .req0(req0), .req1(req1),
      .data0(data0), .data1(data1), .ack0(g_ack0), .ack1(g_ack1),
      .tx_send(g_send), .tx_data(g_data), .busy(g_busy), .byte_cnt(g_cnt),
      .dbg_state(g_st)
   );

   assign o_ack0 = sel ? g_ack0 : a_ack0;
   assign o_ack1 = sel ? g_ack1 : a_ack1;
   assign o_send = sel ? g_send : a_send;
   assign o_busy = sel ? g_busy : a_busy;
   assign o_data = sel ? g_data : a_data;
   assign o_cnt  = sel ? g_cnt  : a_cnt;
   assign o_st   = sel ? g_st   : a_st;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      rr       = 1'b0;
      exp_data = 8'h00;
      exp_cnt  = 8'h00;
      g_at     = -1000;
      free_at  = cyc;
   endtask

   // One clock: apply inputs, predict, advance, compare every output.
   task automatic step(input bit e, input bit r0, input bit r1,
                       input logic [7:0] d0, input logic [7:0] d1);
      int  span;
      bit  exp_send;
      span  = F + (sel ? 3 : 0) + 2;
      en    = e;
      req0  = r0;
      req1  = r1;
      data0 = d0;
      data1 = d1;
      if (cyc >= free_at && e && (r0 || r1)) begin
         w_last = (r0 && r1) ? rr : r1;
         if (r0 && r1) rr = ~rr;
         exp_data = w_last ? d1 : d0;
         g_at     = cyc;
         free_at  = cyc + span;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == g_at + 2) exp_cnt = exp_cnt + 8'd1;
      exp_send = (cyc == g_at + 1);
      chk("tx_send", o_send, exp_send);
      chk("ack0", o_ack0, exp_send && !w_last);
      chk("ack1", o_ack1, exp_send && w_last);
      chk("tx_data", o_data, exp_data);
      chk("busy", o_busy, (cyc > g_at) && (cyc < free_at));
      chk("byte_cnt", o_cnt, exp_cnt);
      chk("ack_excl", o_ack0 & o_ack1, 1'b0);
      if (o_send) begin
         send_q.push_back(cyc);
         data_q.push_back(o_data);
      end
   endtask

   task automatic chk_spacing(input int span);
      for (int i = 1; i < send_q.size(); i++) begin
         chk("spacing", send_q[i] - send_q[i-1], span);
      end
   endtask

   initial begin
      int busy_n;
      sel   = 1'b0;
      rst_n = 1'b0;
      en    = 1'b1;
      req0  = 1'b1;
      req1  = 1'b0;
      data0 = 8'h41;
      data1 = 8'h00;

      // reset held with a live request
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_send", a_send, 1'b0);
         chk("rst_ack0", a_ack0, 1'b0);
         chk("rst_ack1", a_ack1, 1'b0);
         chk("rst_busy", a_busy, 1'b0);
         chk("rst_data", a_data, 8'h00);
         chk("rst_cnt", a_cnt, 8'h00);
         chk("rst_state", a_st, 2'd0);
      end
      rst_n = 1'b1;
      model_reset();

      // single request
      step(1, 1, 0, 8'h41, 8'h00);
      chk("single_send", o_send, 1'b1);
      chk("single_ack0", o_ack0, 1'b1);
      chk("single_data", o_data, 8'h41);
      busy_n = o_busy ? 1 : 0;
      repeat (16) begin
         step(1, 0, 0, 8'h00, 8'h00);
         if (o_busy) busy_n++;
      end
      chk("single_busy_len", busy_n, 13);
      chk("single_cnt", o_cnt, 8'h01);

      // contention
      send_q.delete();
      data_q.delete();
      repeat (56) step(1, 1, 1, 8'h55, 8'hAA);
      chk("cont_sends", send_q.size(), 4);
      if (data_q.size() == 4) begin
         chk("cont_d0", data_q[0], 8'h55);
         chk("cont_d1", data_q[1], 8'hAA);
         chk("cont_d2", data_q[2], 8'h55);
         chk("cont_d3", data_q[3], 8'hAA);
      end
      chk_spacing(14);
      repeat (14) step(1, 0, 0, 8'h00, 8'h00);

      // enable gating
      send_q.delete();
      repeat (30) step(0, 0, 1, 8'h00, 8'h99);
      chk("en_block", send_q.size(), 0);
      step(1, 0, 1, 8'h00, 8'h99);
      chk("en_send", o_send, 1'b1);
      chk("en_ack1", o_ack1, 1'b1);
      repeat (14) step(1, 0, 0, 8'h00, 8'h00);

      // random traffic
      send_q.delete();
      repeat (300) begin
         step($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end
      repeat (20) step(1, 0, 0, 8'h00, 8'h00);

      // reset in WAIT cycle 5
      step(1, 1, 0, 8'h5A, 8'h00);
      repeat (5) step(1, 0, 0, 8'h00, 8'h00);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst_send", o_send, 1'b0);
      chk("mrst_busy", o_busy, 1'b0);
      chk("mrst_data", o_data, 8'h00);
      chk("mrst_cnt", o_cnt, 8'h00);
      chk("mrst_state", o_st, 2'd0);
      @(posedge clk);
      #1;
      chk("mrst_hold_send", o_send, 1'b0);
      rst_n = 1'b1;
      model_reset();
      step(1, 1, 1, 8'h11, 8'h22);
      chk("mrst_first_ack0", o_ack0, 1'b1);
      chk("mrst_first_data", o_data, 8'h11);
      repeat (14) step(1, 0, 0, 8'h00, 8'h00);

      // gap instance, long run for counter wrap
      sel   = 1'b1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      send_q.delete();
      repeat (4369) begin
         step(1, 1, 0, 8'h3C, 8'h00);
         if (o_cnt == 8'hFF && cyc == g_at + 2) chk("wrap_ff", o_cnt, exp_cnt);
      end
      chk("gap_sends", send_q.size(), 257);
      chk_spacing(17);
      chk("wrap_final", o_cnt, 8'h01);
      repeat (60) begin
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
